// File: rtl/cpu_bus_decoder.sv
// CPU bus decoder: routes 8-bit CPU accesses either to a mirrored internal work
// RAM or to one of three external targets (PPU, APU/IO, cartridge). External
// accesses time out, and a timed-out read returns the last value seen on the bus.
// Ports: clock_i/reset_n_i; cpu_* request/response side; ext_* external target side.
// Latency: RAM access ready 2 cycles after valid; external ready 1 cycle after ack/timeout.
// Backpressure: cpu_busy_o high outside IDLE; requests presented while busy are dropped.
module cpu_bus_decoder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RAM_ADDR_WIDTH = 11
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_write_i,
    input  logic        cpu_valid_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_ready_o,
    output logic        cpu_busy_o,
    output logic [1:0]  ext_target_o,
    output logic [15:0] ext_address_o,
    output logic [7:0]  ext_data_o,
    output logic        ext_write_o,
    output logic        ext_request_o,
    input  logic [7:0]  ext_data_i,
    input  logic        ext_ack_i
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    // Timeout fires on the last permitted request cycle, giving exactly
    // TIMEOUT_CYCLES cycles with ext_request_o high.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] TGT_PPU  = 2'd0;
    localparam logic [1:0] TGT_APU  = 2'd1;
    localparam logic [1:0] TGT_CART = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RAM_ACCESS = 2'd1,
        S_EXT_WAIT   = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [RAM_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]                req_data_q, req_data_d;
    logic                      req_write_q, req_write_d;
    logic [1:0]                ext_target_q, ext_target_d;
    logic [15:0]               ext_address_q, ext_address_d;
    logic [7:0]                ext_data_q, ext_data_d;
    logic                      ext_write_q, ext_write_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                open_bus_q, open_bus_d;
    logic [7:0]                cpu_data_q, cpu_data_d;

    logic [7:0] ram_mem [RAM_DEPTH];
    logic [7:0] ram_rdata;
    logic       ram_we;

    // Address decode of the incoming request
    logic        dec_is_ram;
    logic        dec_is_ppu;
    logic        dec_is_apu;
    logic [1:0]  dec_target;
    logic [15:0] dec_ext_address;

    always_comb begin
        dec_is_ram      = (cpu_address_i[15:13] == 3'b000);
        dec_is_ppu      = (cpu_address_i[15:13] == 3'b001);
        dec_is_apu      = (cpu_address_i[15:5] == 11'h200);
        dec_target      = TGT_CART;
        dec_ext_address = cpu_address_i;
        if (dec_is_ppu) begin
            dec_target      = TGT_PPU;
            // PPU has 8 registers mirrored across the whole $2000-$3FFF window
            dec_ext_address = {13'h0400, cpu_address_i[2:0]};
        end else if (dec_is_apu) begin
            dec_target = TGT_APU;
        end
    end

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_valid_i) begin
                    state_d = dec_is_ram ? S_RAM_ACCESS : S_EXT_WAIT;
                end
            end
            S_RAM_ACCESS: state_d = S_DONE;
            S_EXT_WAIT: begin
                if (ext_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cpu_ready_o   = (state_q == S_DONE);
        cpu_busy_o    = (state_q != S_IDLE);
        ext_request_o = (state_q == S_EXT_WAIT);
    end

    // Datapath next-state
    always_comb begin
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        req_write_d   = req_write_q;
        ext_target_d  = ext_target_q;
        ext_address_d = ext_address_q;
        ext_data_d    = ext_data_q;
        ext_write_d   = ext_write_q;
        cnt_d         = cnt_q;
        open_bus_d    = open_bus_q;
        cpu_data_d    = cpu_data_q;
        ram_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_valid_i) begin
                    req_addr_d  = cpu_address_i[RAM_ADDR_WIDTH-1:0];
                    req_data_d  = cpu_data_i;
                    req_write_d = cpu_write_i;
                    cnt_d       = '0;
                    // External pins only move for external accesses
                    if (!dec_is_ram) begin
                        ext_target_d  = dec_target;
                        ext_address_d = dec_ext_address;
                        ext_data_d    = cpu_data_i;
                        ext_write_d   = cpu_write_i;
                    end
                end
            end
            S_RAM_ACCESS: begin
                if (req_write_q) begin
                    ram_we     = 1'b1;
                    open_bus_d = req_data_q;
                end else begin
                    cpu_data_d = ram_rdata;
                    open_bus_d = ram_rdata;
                end
            end
            S_EXT_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ext_ack_i) begin
                    if (req_write_q) begin
                        open_bus_d = req_data_q;
                    end else begin
                        cpu_data_d = ext_data_i;
                        open_bus_d = ext_data_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Nobody drove the bus: reads see the last latched value,
                    // writes leave it untouched
                    if (!req_write_q) begin
                        cpu_data_d = open_bus_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_write_q   <= 1'b0;
            ext_target_q  <= 2'd0;
            ext_address_q <= 16'h0000;
            ext_data_q    <= 8'h00;
            ext_write_q   <= 1'b0;
            cnt_q         <= '0;
            open_bus_q    <= 8'h00;
            cpu_data_q    <= 8'h00;
        end else begin
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            req_write_q   <= req_write_d;
            ext_target_q  <= ext_target_d;
            ext_address_q <= ext_address_d;
            ext_data_q    <= ext_data_d;
            ext_write_q   <= ext_write_d;
            cnt_q         <= cnt_d;
            open_bus_q    <= open_bus_d;
            cpu_data_q    <= cpu_data_d;
        end
    end

    // Work RAM keeps its contents across reset
    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            ram_mem[req_addr_q] <= req_data_q;
        end
    end

    assign ram_rdata = ram_mem[req_addr_q];

    assign cpu_data_o    = cpu_data_q;
    assign ext_target_o  = ext_target_q;
    assign ext_address_o = ext_address_q;
    assign ext_data_o    = ext_data_q;
    assign ext_write_o   = ext_write_q;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Bench for cpu_bus_decoder: directed accesses push expected responses to a
// scoreboard queue; a negedge monitor pops and checks on every ready pulse.
// Ext pin values and reset behaviour are checked directly by the driver.
module tb_cpu_bus_decoder;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [15:0] cpu_address_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_write_i;
    logic        cpu_valid_i;
    logic [7:0]  cpu_data_o;
    logic        cpu_ready_o;
    logic        cpu_busy_o;
    logic [1:0]  ext_target_o;
    logic [15:0] ext_address_o;
    logic [7:0]  ext_data_o;
    logic        ext_write_o;
    logic        ext_request_o;
    logic [7:0]  ext_data_i;
    logic        ext_ack_i;

    cpu_bus_decoder #(.TIMEOUT_CYCLES(16), .RAM_ADDR_WIDTH(11)) dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .cpu_address_i (cpu_address_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_valid_i   (cpu_valid_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_ready_o   (cpu_ready_o),
        .cpu_busy_o    (cpu_busy_o),
        .ext_target_o  (ext_target_o),
        .ext_address_o (ext_address_o),
        .ext_data_o    (ext_data_o),
        .ext_write_o   (ext_write_o),
        .ext_request_o (ext_request_o),
        .ext_data_i    (ext_data_i),
        .ext_ack_i     (ext_ack_i)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc = cyc + 1;

    typedef struct {
        int data;
        int rdy_cyc;
        int req;      // expected request cycles, -1 = don't care
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   req_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts request cycles and checks every completion
    always @(negedge clock_i) begin
        if (!reset_n_i) begin
            req_run = 0;
        end else begin
            if (ext_request_o) req_run = req_run + 1;
            if (cpu_ready_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", int'(cpu_data_o), e.data);
                    chk("ready_cycle", cyc, e.rdy_cyc);
                    if (e.req >= 0) chk("req_cycles", req_run, e.req);
                end
                req_run = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && cpu_busy_o; i++) begin
            @(posedge clock_i); #1;
        end
        if (cpu_busy_o) chk("idle_timeout", 1, 0);
    endtask

    // One CPU access. ack_n = request cycle on which ack is driven (0 = never).
    // dup = keep valid asserted through EXT_WAIT and pulse it again in DONE.
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic wr,
                          input int ack_n, input logic [7:0] ack_d,
                          input int exp_d, input int lat, input int req,
                          input int tgt, input logic [15:0] eaddr, input bit dup);
        exp_t e;
        wait_idle();
        cpu_address_i = a;
        cpu_data_i    = d;
        cpu_write_i   = wr;
        cpu_valid_i   = 1'b1;
        e.data = exp_d; e.rdy_cyc = cyc + lat; e.req = req;
        sb.push_back(e);
        @(posedge clock_i); #1;
        if (dup) begin
            cpu_address_i = 16'h0005;
            cpu_write_i   = 1'b0;
        end else begin
            cpu_valid_i = 1'b0;
        end
        if (tgt >= 0) begin
            chk("ext_request", int'(ext_request_o), 1);
            chk("ext_target", int'(ext_target_o), tgt);
            chk("ext_address", int'(ext_address_o), int'(eaddr));
            chk("ext_write", int'(ext_write_o), int'(wr));
            if (wr) chk("ext_data", int'(ext_data_o), int'(d));
        end else begin
            chk("ram_no_request", int'(ext_request_o), 0);
        end
        if (ack_n > 0) begin
            repeat (ack_n - 1) begin
                @(posedge clock_i); #1;
            end
            cpu_valid_i = 1'b0;
            ext_ack_i   = 1'b1;
            ext_data_i  = ack_d;
            @(posedge clock_i); #1;
            ext_ack_i   = 1'b0;
            if (dup) begin
                cpu_valid_i = 1'b1;
                @(posedge clock_i); #1;
                cpu_valid_i = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        reset_n_i     = 1'b0;
        cpu_address_i = 16'h0000;
        cpu_data_i    = 8'h00;
        cpu_write_i   = 1'b0;
        cpu_valid_i   = 1'b0;
        ext_data_i    = 8'h00;
        ext_ack_i     = 1'b0;
        #12;
        chk("rst_ready", int'(cpu_ready_o), 0);
        chk("rst_busy", int'(cpu_busy_o), 0);
        chk("rst_request", int'(ext_request_o), 0);
        chk("rst_target", int'(ext_target_o), 0);
        chk("rst_address", int'(ext_address_o), 0);
        chk("rst_data_o", int'(cpu_data_o), 0);
        @(posedge clock_i); #1;
        reset_n_i = 1'b1;

        // RAM write then mirrored read
        access(16'h0005, 8'hA5, 1'b1, 0, 8'h00, 8'h00, 2, 0, -1, 16'h0, 1'b0);
        access(16'h0805, 8'h00, 1'b0, 0, 8'h00, 8'hA5, 2, 0, -1, 16'h0, 1'b0);
        // PPU read, ack on 3rd request cycle
        access(16'h3FFE, 8'h00, 1'b0, 3, 8'h3C, 8'h3C, 4, 3, 0, 16'h2006, 1'b0);
        // Write holds cpu_data_o; read back $77 primes open bus
        access(16'h0100, 8'h77, 1'b1, 0, 8'h00, 8'h3C, 2, 0, -1, 16'h0, 1'b0);
        access(16'h0100, 8'h00, 1'b0, 0, 8'h00, 8'h77, 2, 0, -1, 16'h0, 1'b0);
        // Cartridge read timeout returns open bus
        access(16'h8000, 8'h00, 1'b0, 0, 8'h00, 8'h77, 17, 16, 2, 16'h8000, 1'b0);
        // APU write, ack data ignored; open bus becomes $02
        access(16'h4014, 8'h02, 1'b1, 1, 8'hFF, 8'h77, 2, 1, 1, 16'h4014, 1'b0);
        // Timed-out write must not touch open bus
        access(16'h6000, 8'h99, 1'b1, 0, 8'h00, 8'h77, 17, 16, 2, 16'h6000, 1'b0);
        access(16'h9000, 8'h00, 1'b0, 0, 8'h00, 8'h02, 17, 16, 2, 16'h9000, 1'b0);
        // Ack coinciding with timeout: ack wins
        access(16'h5000, 8'h00, 1'b0, 16, 8'h5A, 8'h5A, 17, 16, 2, 16'h5000, 1'b0);
        // APU/cartridge boundary
        access(16'h401F, 8'h00, 1'b0, 1, 8'hC3, 8'hC3, 2, 1, 1, 16'h401F, 1'b0);
        access(16'h4020, 8'h00, 1'b0, 1, 8'hD4, 8'hD4, 2, 1, 2, 16'h4020, 1'b0);
        // Extra valids during EXT_WAIT and DONE are dropped
        access(16'h2000, 8'h00, 1'b0, 2, 8'h11, 8'h11, 3, 2, 0, 16'h2000, 1'b1);
        repeat (4) @(posedge clock_i);
        #1;

        // Reset during EXT_WAIT: request drops with no clock edge
        cpu_address_i = 16'h8000;
        cpu_write_i   = 1'b0;
        cpu_valid_i   = 1'b1;
        @(posedge clock_i); #1;
        cpu_valid_i = 1'b0;
        @(posedge clock_i); #1;
        chk("pre_rst_request", int'(ext_request_o), 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_request", int'(ext_request_o), 0);
        chk("async_rst_busy", int'(cpu_busy_o), 0);
        chk("async_rst_data", int'(cpu_data_o), 0);
        chk("async_rst_target", int'(ext_target_o), 0);
        chk("async_rst_address", int'(ext_address_o), 0);
        repeat (2) @(posedge clock_i);
        #1;
        reset_n_i = 1'b1;
        // RAM survives reset; accepted on the first cycle out of reset
        access(16'h0005, 8'h00, 1'b0, 0, 8'h00, 8'hA5, 2, 0, -1, 16'h0, 1'b0);

        repeat (4) @(posedge clock_i);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_bus_decoder.md
CPU_BUS_DECODER -- requirements
Module: cpu_bus_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum external-request cycles without ack before the access is forced complete.
REQ-002 Parameter: RAM_ADDR_WIDTH, default 11, internal work-RAM address width (2 KiB).
REQ-003 clock_i  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 cpu_address_i  input  16  CPU access address.
REQ-006 cpu_data_i  input  8  CPU write data.
REQ-007 cpu_write_i  input  1  1 = write, 0 = read; sampled with cpu_valid_i.
REQ-008 cpu_valid_i  input  1  request strobe; one accepted per IDLE cycle.
REQ-009 cpu_data_o  output  8  read data; meaningful when cpu_ready_o = 1.
REQ-010 cpu_ready_o  output  1  one-cycle completion pulse.
REQ-011 cpu_busy_o  output  1  high whenever state is not IDLE.
REQ-012 ext_target_o  output  2  0 = PPU, 1 = APU/IO, 2 = cartridge.
REQ-013 ext_address_o  output  16  address presented to the external target.
REQ-014 ext_data_o  output  8  external write data.
REQ-015 ext_write_o  output  1  external access direction.
REQ-016 ext_request_o  output  1  external access request, held until ack or timeout.
REQ-017 ext_data_i  input  8  external read data; valid with ext_ack_i.
REQ-018 ext_ack_i  input  1  external completion.

Function
REQ-019 States: IDLE, RAM_ACCESS, EXT_WAIT, DONE.
REQ-020 IDLE: on cpu_valid_i = 1, latch address, data and write, then decode as follows.
REQ-021 Decode: $0000-$1FFF goes to RAM_ACCESS, RAM index = address[10:0] (mirrored).
REQ-022 Decode: $2000-$3FFF goes to EXT_WAIT, target 0, ext_address_o = $2000 | address[2:0].
REQ-023 Decode: $4000-$401F goes to EXT_WAIT, target 1; $4020-$FFFF goes to EXT_WAIT, target 2; ext_address_o = address unmodified in both cases.
REQ-024 RAM_ACCESS: a write updates RAM; a read produces registered RAM data; the next state is DONE. Read latency is ready asserted 2 cycles after the valid cycle.
REQ-025 EXT_WAIT: ext_request_o = 1 and the timeout counter increments each cycle.
REQ-026 EXT_WAIT exit on ack: when ext_ack_i = 1, capture ext_data_i for reads and go to DONE; cpu_ready_o is asserted the cycle after the ack.
REQ-027 EXT_WAIT exit on timeout: when the counter reaches TIMEOUT_CYCLES without ack, go to DONE and return the open-bus value for reads.
REQ-028 Ack and timeout in the same cycle: ack wins, and ext_data_i is returned.
REQ-029 DONE: cpu_ready_o = 1 for exactly one cycle, then IDLE.
REQ-030 cpu_valid_i in any non-IDLE state (including DONE) is ignored; requests are not queued.
REQ-031 ext_ack_i outside EXT_WAIT is ignored.
REQ-032 Open-bus register: updated with the data of every completed read (RAM or ack'd external) and every write.
REQ-033 Timed-out reads return the open-bus register; timed-out writes do not update it.
REQ-034 ext_request_o is deasserted in the DONE cycle.
REQ-035 The counter clears when EXT_WAIT is entered.
REQ-036 For writes, cpu_data_o holds its previous value.

Reset
REQ-037 reset_n_i = 0 immediately (asynchronously) forces: state IDLE, cpu_ready_o = 0, cpu_busy_o = 0, ext_request_o = 0, ext_write_o = 0, ext_target_o = 0, ext_address_o = $0000, ext_data_o = $00, cpu_data_o = $00, open-bus register = $00, counter = 0.
REQ-038 Reset mid-access abandons the access with no ready pulse; RAM contents are not cleared.
REQ-039 Requests are accepted the first cycle reset_n_i is high.

Verification
REQ-040 RAM mirroring: write $A5 to $0005, then read $0805 -> cpu_data_o = $A5; ready 2 cycles after valid; no ext_request_o.
REQ-041 PPU access: read $3FFE -> ext_target_o = 0, ext_address_o = $2006; ack after 3 cycles with ext_data_i = $3C -> cpu_data_o = $3C, ready the cycle after ack.
REQ-042 Cartridge timeout: after a prior read of $77, read $8000 with no ack -> exactly 16 request cycles, then ready with cpu_data_o = $77.
REQ-043 Busy handling: second cpu_valid_i pulsed during EXT_WAIT and during DONE -> exactly one cpu_ready_o pulse.
REQ-044 Reset mid-access: reset_n_i low during EXT_WAIT -> ext_request_o drops without a clock edge; a subsequent read of $0005 returns $A5.
REQ-045 APU/IO write: write $02 to $4014 -> ext_target_o = 1, ext_write_o = 1, ext_data_o = $02, ext_address_o = $4014; ack with ext_data_i = $FF leaves cpu_data_o unchanged.
